// File: rtl/conv_3x3_stream_accum.sv
// Streaming 3x3 convolution with zero padding, stride 1/2 and cross-channel accumulation.
// Emits one saturated output map per frame after the last input channel.
module conv_3x3_stream_accum #(
   parameter int DATA_WIDTH     = 16,
   parameter int FRAC_BITS      = 8,
   parameter int IMAGE_WIDTH    = 4,
   parameter int IMAGE_HEIGHT   = 4,
   parameter int CHANNEL_NUM_IN = 2,
   parameter int ACC_WIDTH      = 2 * DATA_WIDTH + 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  stride2,
   input  logic                  valid_weight_in,
   input  logic [DATA_WIDTH-1:0] weight_in,
   input  logic                  valid_in,
   input  logic [DATA_WIDTH-1:0] pxl_in,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] pxl_out,
   output logic                  valid_out,
   output logic                  frame_done
);
   localparam int W     = IMAGE_WIDTH;
   localparam int H     = IMAGE_HEIGHT;
   localparam int C     = CHANNEL_NUM_IN;
   localparam int DW    = DATA_WIDTH;
   localparam int PW    = 2 * DATA_WIDTH;
   localparam int WN    = 9 * C + 1;
   localparam int WAW   = $clog2(WN);
   localparam int DEPTH = W * H;
   localparam int KW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int RW    = $clog2(H + 1);
   localparam int CLW   = $clog2(W + 1);
   localparam int CW    = (C > 1) ? $clog2(C) : 1;
   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
      {{(ACC_WIDTH-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
      {{(ACC_WIDTH-DW+1){1'b1}}, {(DW-1){1'b0}}};

   typedef enum logic [1:0] {StLoad, StReady, StRun, StDrain} state_e;

   state_e                       state_q;
   logic                         wt_loaded_q, stride_q;
   logic [WAW-1:0]               wptr_q, wbase_q;
   logic [RW-1:0]                r_q;
   logic [CLW-1:0]               c_q;
   logic [CW-1:0]                ch_q;
   logic [KW-1:0]                k_q;
   logic [1:0]                   drain_q;
   logic signed [DW-1:0]         wram [WN];
   logic signed [ACC_WIDTH-1:0]  acc_mem [DEPTH];
   logic signed [DW-1:0]         lb1_q [W+1];
   logic signed [DW-1:0]         lb2_q [W+1];
   logic signed [DW-1:0]         win_q [3][3];
   logic signed [DW-1:0]         win_n [3][3];
   logic signed [DW-1:0]         tap [9];
   logic signed [DW-1:0]         tap_w [9];
   logic signed [PW-1:0]         prod_d [9];

   logic                         s1_vld_q, s1_first_q, s1_last_q;
   logic [KW-1:0]                s1_k_q;
   logic signed [PW-1:0]         s1_prod_q [9];
   logic signed [ACC_WIDTH-1:0]  s1_acc_q;
   logic                         s2_vld_q, s2_first_q, s2_last_q;
   logic [KW-1:0]                s2_k_q;
   logic signed [ACC_WIDTH-1:0]  s2_sum_q, s2_acc_q;

   logic                         real_pos, adv, gen, col_end, row_end, last_ch;
   logic signed [DW-1:0]         pix;
   logic signed [ACC_WIDTH-1:0]  sum_d, bias_sh, acc_new, acc_sh;

   assign real_pos = (r_q < RW'(H)) && (c_q < CLW'(W));
   assign col_end  = (c_q == CLW'(W));
   assign row_end  = (r_q == RW'(H));
   assign last_ch  = (ch_q == CW'(C - 1));
   assign in_ready = wt_loaded_q && ((state_q == StReady) || ((state_q == StRun) && real_pos));
   // Pad positions advance on their own; real positions wait for the handshake.
   assign adv      = (in_ready && valid_in) || ((state_q == StRun) && !real_pos);
   assign pix      = real_pos ? pxl_in : '0;
   assign gen      = adv && (state_q == StRun) && (r_q != '0) && (c_q != '0) &&
                     (!stride_q || (r_q[0] && c_q[0]));
   assign bias_sh  = ACC_WIDTH'(wram[WAW'(WN - 1)]) <<< FRAC_BITS;

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         win_n[i][0] = win_q[i][1];
         win_n[i][1] = win_q[i][2];
      end
      win_n[0][2] = lb2_q[W];
      win_n[1][2] = lb1_q[W];
      win_n[2][2] = pix;
      // Top row / left column taps fall outside the image for the first row / column.
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            tap[3*i+j] = ((i == 0 && r_q == RW'(1)) || (j == 0 && c_q == CLW'(1))) ?
                         '0 : win_n[i][j];
         end
      end
      for (int j = 0; j < 9; j++) begin
         tap_w[j]  = wram[wbase_q + WAW'(j)];
         prod_d[j] = PW'(tap[j]) * PW'(tap_w[j]);
      end
   end

   always_comb begin
      sum_d = '0;
      for (int j = 0; j < 9; j++) sum_d = sum_d + ACC_WIDTH'(s1_prod_q[j]);
      acc_new = s2_first_q ? (s2_sum_q + bias_sh) : (s2_acc_q + s2_sum_q);
      acc_sh  = acc_new >>> FRAC_BITS;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StLoad;
         wt_loaded_q <= 1'b0;
         stride_q    <= 1'b0;
         wptr_q      <= '0;
         wbase_q     <= '0;
         r_q         <= '0;
         c_q         <= '0;
         ch_q        <= '0;
         k_q         <= '0;
         drain_q     <= '0;
         win_q       <= '{default: '0};
         s1_vld_q    <= 1'b0;
         s2_vld_q    <= 1'b0;
         valid_out   <= 1'b0;
         pxl_out     <= '0;
         frame_done  <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         unique case (state_q)
            StLoad: if (valid_weight_in) begin
               if (wptr_q == WAW'(WN - 1)) begin
                  wptr_q      <= '0;
                  wt_loaded_q <= 1'b1;
                  state_q     <= StReady;
               end else begin
                  wptr_q <= wptr_q + 1'b1;
               end
            end
            StReady: if (valid_in) begin
               stride_q <= stride2;
               state_q  <= StRun;
            end else if (valid_weight_in) begin
               wt_loaded_q <= 1'b0;
               wptr_q      <= WAW'(1);
               state_q     <= StLoad;
            end
            StRun: if (adv && col_end && row_end && last_ch) state_q <= StDrain;
            StDrain: if (drain_q == 2'd2) begin
               drain_q    <= '0;
               state_q    <= StReady;
               frame_done <= 1'b1;
            end else begin
               drain_q <= drain_q + 1'b1;
            end
            default: state_q <= StLoad;
         endcase

         if (adv) begin
            win_q <= win_n;
            if (col_end) begin
               c_q <= '0;
               if (row_end) begin
                  r_q     <= '0;
                  ch_q    <= last_ch ? '0 : ch_q + 1'b1;
                  wbase_q <= last_ch ? '0 : wbase_q + WAW'(9);
               end else begin
                  r_q <= r_q + 1'b1;
               end
            end else begin
               c_q <= c_q + 1'b1;
            end
         end
         if (adv && col_end && row_end) k_q <= '0;
         else if (gen)                  k_q <= k_q + 1'b1;

         s1_vld_q  <= gen;
         s2_vld_q  <= s1_vld_q;
         valid_out <= s2_vld_q && s2_last_q;
         if (s2_vld_q && s2_last_q) begin
            if (acc_sh > SAT_MAX)      pxl_out <= {1'b0, {(DW-1){1'b1}}};
            else if (acc_sh < SAT_MIN) pxl_out <= {1'b1, {(DW-1){1'b0}}};
            else                       pxl_out <= acc_sh[DW-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      s1_k_q     <= k_q;
      s1_first_q <= (ch_q == '0);
      s1_last_q  <= last_ch;
      s1_prod_q  <= prod_d;
      s1_acc_q   <= acc_mem[k_q];
      s2_k_q     <= s1_k_q;
      s2_first_q <= s1_first_q;
      s2_last_q  <= s1_last_q;
      s2_sum_q   <= sum_d;
      s2_acc_q   <= s1_acc_q;
      if (adv) begin
         for (int i = W; i > 0; i--) begin
            lb1_q[i] <= lb1_q[i-1];
            lb2_q[i] <= lb2_q[i-1];
         end
         lb1_q[0] <= pix;
         lb2_q[0] <= lb1_q[W];
      end
      if (!reset && s2_vld_q && !s2_last_q) acc_mem[s2_k_q] <= acc_new;
      if (!reset && valid_weight_in) begin
         if (state_q == StLoad)                 wram[wptr_q]   <= weight_in;
         else if (state_q == StReady && !valid_in) wram[WAW'(0)] <= weight_in;
      end
   end
endmodule
